// File: rtl/ahb_dma_copy_if.sv
// AHB-Lite bus bundle for the ahb_dma_copy master.
// The master modport drives the address/control/write-data side; the slave modport returns read data, ready and response.
interface ahb_dma_copy_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_dma_copy.sv
// Single-channel AHB-Lite DMA master copying a block of 32-bit words, one read then one write per word.
// Define AHB_DMA_COPY_IRQ_EN to enable the sticky completion interrupt; otherwise irq is tied low.
module ahb_dma_copy #(
    parameter int LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             irq,
    input  logic             irq_clr,
    ahb_dma_copy_if.master   bus
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_D, FIN} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    state_t           state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [31:0]      data_buf;
    logic [LEN_W-1:0] cnt;

    logic addr_lsb_unused;
    assign addr_lsb_unused = ^{src_addr[1:0], dst_addr[1:0]};

    assign bus.HSIZE  = 3'b010;
    assign bus.HBURST = 3'b000;
    assign bus.HPROT  = 4'b0011;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            src        <= '0;
            dst        <= '0;
            data_buf   <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            bus.HADDR  <= '0;
            bus.HTRANS <= TR_IDLE;
            bus.HWRITE <= 1'b0;
            bus.HWDATA <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (len != '0) begin
                            src        <= {src_addr[31:2], 2'b00};
                            dst        <= {dst_addr[31:2], 2'b00};
                            cnt        <= len;
                            bus.HADDR  <= {src_addr[31:2], 2'b00};
                            bus.HTRANS <= TR_NONSEQ;
                            bus.HWRITE <= 1'b0;
                            state      <= RD_A;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                RD_A: begin
                    if (bus.HREADY) begin
                        bus.HTRANS <= TR_IDLE;
                        state      <= RD_D;
                    end
                end
                RD_D: begin
                    // Leave on the first ERROR cycle; FIN keeps HTRANS at IDLE through the second one.
                    if (bus.HRESP) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (bus.HREADY) begin
                        data_buf   <= bus.HRDATA;
                        src        <= src + 32'd4;
                        bus.HADDR  <= dst;
                        bus.HTRANS <= TR_NONSEQ;
                        bus.HWRITE <= 1'b1;
                        state      <= WR_A;
                    end
                end
                WR_A: begin
                    if (bus.HREADY) begin
                        bus.HTRANS <= TR_IDLE;
                        bus.HWDATA <= data_buf;
                        state      <= WR_D;
                    end
                end
                WR_D: begin
                    if (bus.HRESP) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (bus.HREADY) begin
                        dst <= dst + 32'd4;
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            bus.HADDR  <= src;
                            bus.HTRANS <= TR_NONSEQ;
                            bus.HWRITE <= 1'b0;
                            state      <= RD_A;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    bus.HTRANS <= TR_IDLE;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef AHB_DMA_COPY_IRQ_EN
    // Set has priority so a clear landing on the done cycle cannot lose the event.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`else
    logic irq_clr_unused;
    assign irq_clr_unused = irq_clr;
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_dma_copy.sv
// Directed bench for ahb_dma_copy with a behavioural AHB-Lite memory slave (wait states, two-cycle ERROR).
// Expectations follow AHB_DMA_COPY_IRQ_EN the same way the design does.
module tb_ahb_dma_copy;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic        irq_clr = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, err, irq;

    ahb_dma_copy_if bus ();

    ahb_dma_copy #(.LEN_W(16)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .irq      (irq),
        .irq_clr  (irq_clr),
        .bus      (bus)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // Read-only source image and a separate write image.
    logic [31:0] mem  [0:255];
    logic [31:0] wmem [0:255];

    logic        dp_act = 1'b0, dp_wr = 1'b0, dp_err = 1'b0, err_second = 1'b0;
    logic [31:0] dp_addr = '0, last_rd_addr = '0;
    int          wait_cnt = 0, waits = 0, rd_num = 0, err_read = 0;
    int          nonseq_cnt = 0, wr_cnt = 0, done_cnt = 0;

    always_comb begin
        bus.HRESP = dp_act && dp_err;
        if (!dp_act)     bus.HREADY = 1'b1;
        else if (dp_err) bus.HREADY = err_second;
        else             bus.HREADY = (wait_cnt == 0);
        bus.HRDATA = (dp_act && !dp_wr) ? mem[dp_addr[9:2]] : 32'hDEAD_BEEF;
    end

    always @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_act <= 1'b0;
        end else begin
            if (dp_act && bus.HREADY && dp_wr && !dp_err) begin
                wmem[dp_addr[9:2]] <= bus.HWDATA;
                wr_cnt <= wr_cnt + 1;
            end
            if (dp_act && !bus.HREADY) begin
                if (dp_err) err_second <= 1'b1;
                else        wait_cnt <= wait_cnt - 1;
            end
            if (bus.HREADY) begin
                if (bus.HTRANS == 2'b10) begin
                    dp_act     <= 1'b1;
                    dp_wr      <= bus.HWRITE;
                    dp_addr    <= bus.HADDR;
                    wait_cnt   <= waits;
                    err_second <= 1'b0;
                    nonseq_cnt <= nonseq_cnt + 1;
                    if (!bus.HWRITE) begin
                        rd_num       <= rd_num + 1;
                        last_rd_addr <= bus.HADDR;
                        dp_err       <= (rd_num + 1 == err_read);
                    end else begin
                        dp_err <= 1'b0;
                    end
                end else begin
                    dp_act <= 1'b0;
                end
            end
        end
    end

    always @(posedge HCLK) if (done) done_cnt <= done_cnt + 1;

    // Outputs seen in the cycle after a wait must equal those seen during the wait.
    logic        mon_en = 1'b0, prev_wait = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [1:0]  prev_trans = '0;
    int          hold_bad = 0, hold_seen = 0;
    always @(negedge HCLK) begin
        if (mon_en && prev_wait) begin
            hold_seen++;
            if (bus.HADDR !== prev_addr || bus.HTRANS !== prev_trans || bus.HWDATA !== prev_wdata)
                hold_bad++;
        end
        prev_wait  = !bus.HREADY;
        prev_addr  = bus.HADDR;
        prev_trans = bus.HTRANS;
        prev_wdata = bus.HWDATA;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Pulse start and return the cycle count from the start cycle to the cycle showing done.
    task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                      input int max, output int lat);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < max) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, n0, w0, d0;
        for (int unsigned i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        mem[64]  = 32'h1111_1111;
        mem[65]  = 32'h2222_2222;
        mem[66]  = 32'h3333_3333;
        mem[67]  = 32'h4444_4444;
        mem[80]  = 32'h5555_5555;
        mem[81]  = 32'h6666_6666;
        mem[82]  = 32'h7777_7777;
        mem[255] = 32'hCAFE_0001;
        mem[0]   = 32'hCAFE_0002;

        tick();
        tick();
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_done", 32'(done), 32'd0);
        check32("rst_err", 32'(err), 32'd0);
        check32("rst_irq", 32'(irq), 32'd0);
        check32("rst_htrans", 32'(bus.HTRANS), 32'd0);
        check32("rst_hwrite", 32'(bus.HWRITE), 32'd0);
        check32("rst_haddr", bus.HADDR, 32'd0);
        check32("rst_hwdata", bus.HWDATA, 32'd0);
        check32("hsize", 32'(bus.HSIZE), 32'd2);
        check32("hburst", 32'(bus.HBURST), 32'd0);
        check32("hprot", 32'(bus.HPROT), 32'd3);
        HRESETn = 1'b1;
        tick();

        // Zero-wait four-word copy.
        n0 = nonseq_cnt;
        go(32'h100, 32'h200, 16'd4, 40, lat);
        check32("t1_latency", lat, 17);
        check32("t1_busy_fin", 32'(busy), 32'd1);
        check32("t1_err", 32'(err), 32'd0);
        check32("t1_w0", wmem[128], 32'h1111_1111);
        check32("t1_w1", wmem[129], 32'h2222_2222);
        check32("t1_w2", wmem[130], 32'h3333_3333);
        check32("t1_w3", wmem[131], 32'h4444_4444);
        check32("t1_nonseq", nonseq_cnt - n0, 8);
        tick();
        check32("t1_done_pulse", 32'(done), 32'd0);
        check32("t1_busy_idle", 32'(busy), 32'd0);

        // Zero-length start.
        n0 = nonseq_cnt;
        go(32'h100, 32'h200, 16'd0, 5, lat);
        check32("t2_latency", lat, 1);
        check32("t2_busy", 32'(busy), 32'd1);
        tick();
        check32("t2_busy_low", 32'(busy), 32'd0);
        check32("t2_done_low", 32'(done), 32'd0);
        check32("t2_no_bus", nonseq_cnt - n0, 0);

        // Two wait states in every data phase.
        waits  = 2;
        mon_en = 1'b1;
        go(32'h100, 32'h240, 16'd2, 60, lat);
        mon_en = 1'b0;
        waits  = 0;
        check32("t3_latency", lat, 17);
        check32("t3_w0", wmem[144], 32'h1111_1111);
        check32("t3_w1", wmem[145], 32'h2222_2222);
        check32("t3_hold_seen", hold_seen, 8);
        check32("t3_hold_bad", hold_bad, 0);
        tick();

        // ERROR on the second read of a three-word copy.
        err_read = rd_num + 2;
        n0 = nonseq_cnt;
        w0 = wr_cnt;
        go(32'h140, 32'h280, 16'd3, 40, lat);
        check32("t4_latency", lat, 7);
        check32("t4_err", 32'(err), 32'd1);
        check32("t4_writes", wr_cnt - w0, 1);
        check32("t4_w0", wmem[160], 32'h5555_5555);
        tick();
        tick();
        tick();
        err_read = 0;
        check32("t4_nonseq", nonseq_cnt - n0, 3);
        check32("t4_err_sticky", 32'(err), 32'd1);
        check32("t4_busy", 32'(busy), 32'd0);
        go(32'h100, 32'h2C0, 16'd1, 20, lat);
        check32("t4_next_latency", lat, 5);
        check32("t4_err_cleared", 32'(err), 32'd0);
        check32("t4_next_w", wmem[176], 32'h1111_1111);
        tick();

        // Start while busy is ignored.
        n0 = nonseq_cnt;
        src_addr = 32'h100;
        dst_addr = 32'h300;
        len      = 16'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        src_addr = 32'h140;
        dst_addr = 32'h380;
        len      = 16'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 4;
        while (done !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        check32("t5_latency", lat, 9);
        check32("t5_w0", wmem[192], 32'h1111_1111);
        check32("t5_w1", wmem[193], 32'h2222_2222);
        check32("t5_nonseq", nonseq_cnt - n0, 4);
        tick();

        // Source pointer wraps past 0xFFFFFFFC; low address bits are dropped.
        go(32'hFFFF_FFFF, 32'h3A2, 16'd2, 30, lat);
        check32("t6_latency", lat, 9);
        check32("t6_w0", wmem[232], 32'hCAFE_0001);
        check32("t6_w1", wmem[233], 32'hCAFE_0002);
        check32("t6_wrap_addr", last_rd_addr, 32'h0);
        tick();

        // Asynchronous reset during the first write data phase.
        d0 = done_cnt;
        src_addr = 32'h100;
        dst_addr = 32'h3C0;
        len      = 16'd4;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check32("t7_in_wr_d", {30'd0, bus.HWRITE, bus.HTRANS == 2'b00}, 32'd3);
        #2 HRESETn = 1'b0;
        #1;
        check32("t7_busy", 32'(busy), 32'd0);
        check32("t7_htrans", 32'(bus.HTRANS), 32'd0);
        check32("t7_hwrite", 32'(bus.HWRITE), 32'd0);
        check32("t7_haddr", bus.HADDR, 32'd0);
        check32("t7_hwdata", bus.HWDATA, 32'd0);
        check32("t7_err", 32'(err), 32'd0);
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
        tick();
        check32("t7_no_done", done_cnt - d0, 0);
        check32("t7_idle", 32'(busy), 32'd0);

        // Interrupt: clear coinciding with done loses, a later clear wins.
        go(32'h100, 32'h3E0, 16'd1, 20, lat);
        check32("t8_latency", lat, 5);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
`ifdef AHB_DMA_COPY_IRQ_EN
        check32("t8_irq_set", 32'(irq), 32'd1);
        tick();
        check32("t8_irq_hold", 32'(irq), 32'd1);
`else
        check32("t8_irq_set", 32'(irq), 32'd0);
        tick();
        check32("t8_irq_hold", 32'(irq), 32'd0);
`endif
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check32("t8_irq_clr", 32'(irq), 32'd0);
        check32("t8_w", wmem[248], 32'h1111_1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
